// File: rtl/scaler_alarm_monitor.sv
// Purpose: checks the A1 scaler outputs (FS02, FS02A, F02A, F02B) on the FS01_ timebase and latches SCAFAL on a violation.
// Latency: inputs are registered at edge n; FAULT/SCAFAL/ERRCNT reflect that sample at edge n+1.
// Backpressure: none; one sample is accepted every FS01_ cycle, and ERRCNT saturates instead of wrapping.
module scaler_alarm_monitor #(
    parameter int SETTLE    = 4,
    parameter int STALL_MAX = 3,
    parameter int WINDOW    = 8,
    parameter int ERRW      = 8
) (
    input  logic            FS01_,
    input  logic            rst,
    input  logic            FS02,
    input  logic            FS02A,
    input  logic            F02A,
    input  logic            F02B,
    input  logic            ALMCLR,
    output logic            SCAFAL,
    output logic [3:0]      FAULT,
    output logic [ERRW-1:0] ERRCNT,
    output logic            LOCKED
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int STW = $clog2(STALL_MAX + 1);
    localparam int WW  = $clog2(WINDOW);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ALARM  = 2'd2
    } state_t;

    state_t         state;
    logic [SCW-1:0] settle_cnt;
    logic [STW-1:0] stall_cnt;
    logic [STW-1:0] stall_nxt;
    logic [WW-1:0]  win_cnt;
    logic [WW-1:0]  win_nxt;
    logic           seen_a;
    logic           seen_b;
    logic           seen_a_nxt;
    logic           seen_b_nxt;
    logic           seen_a_upd;
    logic           seen_b_upd;
    logic           win_end;

    // sample stage
    logic s_fs02;
    logic s_fs02a;
    logic s_f02a;
    logic s_f02b;
    logic s_almclr;
    logic p_fs02;

    logic [3:0] cur_fault;
    logic       any_fault;

    // Register every input once per FS01_ edge; ALMCLR travels with the data it applies to.
    always_ff @(posedge FS01_ or posedge rst) begin
        if (rst) begin
            s_fs02   <= 1'b0;
            s_fs02a  <= 1'b0;
            s_f02a   <= 1'b0;
            s_f02b   <= 1'b0;
            s_almclr <= 1'b0;
            p_fs02   <= 1'b0;
        end else begin
            s_fs02   <= FS02;
            s_fs02a  <= FS02A;
            s_f02a   <= F02A;
            s_f02b   <= F02B;
            s_almclr <= ALMCLR;
            p_fs02   <= s_fs02;
        end
    end

    // Stall run length including the current sample, saturating at STALL_MAX.
    always_comb begin
        stall_nxt = stall_cnt;
        if (s_fs02 != p_fs02) begin
            stall_nxt = '0;
        end else if (stall_cnt != STW'(STALL_MAX)) begin
            stall_nxt = stall_cnt + STW'(1);
        end
    end

    // Window bookkeeping: the terminal sample's own pulses count toward that window.
    always_comb begin
        seen_a_upd = seen_a | s_f02a;
        seen_b_upd = seen_b | s_f02b;
        win_end    = (win_cnt == WW'(WINDOW - 1));
        if (win_end) begin
            win_nxt    = '0;
            seen_a_nxt = 1'b0;
            seen_b_nxt = 1'b0;
        end else begin
            win_nxt    = win_cnt + WW'(1);
            seen_a_nxt = seen_a_upd;
            seen_b_nxt = seen_b_upd;
        end
    end

    assign cur_fault = {win_end & ~(seen_a_upd & seen_b_upd),
                        s_f02a & s_f02b,
                        s_fs02a == s_fs02,
                        stall_nxt == STW'(STALL_MAX)};
    assign any_fault = |cur_fault;

    // Stall counter tracks FS02 continuously, so a stall already running at lock is caught promptly.
    always_ff @(posedge FS01_ or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_nxt;
        end
    end

    // Main FSM: settle, check, alarm; owns all registered outputs and the window state.
    always_ff @(posedge FS01_ or posedge rst) begin
        if (rst) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            seen_a     <= 1'b0;
            seen_b     <= 1'b0;
            SCAFAL     <= 1'b0;
            FAULT      <= 4'b0000;
            ERRCNT     <= '0;
            LOCKED     <= 1'b0;
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (settle_cnt == SCW'(SETTLE - 1)) begin
                        state   <= ST_CHECK;
                        LOCKED  <= 1'b1;
                        win_cnt <= '0;
                        seen_a  <= 1'b0;
                        seen_b  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SCW'(1);
                    end
                end
                ST_CHECK: begin
                    win_cnt <= win_nxt;
                    seen_a  <= seen_a_nxt;
                    seen_b  <= seen_b_nxt;
                    if (any_fault) begin
                        state  <= ST_ALARM;
                        SCAFAL <= 1'b1;
                        FAULT  <= cur_fault;
                    end
                end
                ST_ALARM: begin
                    if (s_almclr && !any_fault) begin
                        // Clean clear: drop the alarm and start a fresh window.
                        state   <= ST_CHECK;
                        SCAFAL  <= 1'b0;
                        FAULT   <= 4'b0000;
                        win_cnt <= '0;
                        seen_a  <= 1'b0;
                        seen_b  <= 1'b0;
                    end else begin
                        win_cnt <= win_nxt;
                        seen_a  <= seen_a_nxt;
                        seen_b  <= seen_b_nxt;
                        // A clear that collides with a fault keeps only the fresh bits.
                        FAULT   <= s_almclr ? cur_fault : (FAULT | cur_fault);
                    end
                end
                default: begin
                    state <= ST_SETTLE;
                end
            endcase

            if ((state != ST_SETTLE) && any_fault && (ERRCNT != {ERRW{1'b1}})) begin
                ERRCNT <= ERRCNT + ERRW'(1);
            end
        end
    end

endmodule

// File: tb/tb_scaler_alarm_monitor.sv
// Purpose: self-checking bench for scaler_alarm_monitor using an expected-value queue.
// Latency: expectations are keyed to the edge after the sample that causes them.
// Backpressure: not applicable; one stimulus sample per FS01_ cycle.
module tb_scaler_alarm_monitor;

    logic       FS01_ = 1'b0;
    logic       rst   = 1'b1;
    logic       FS02  = 1'b0;
    logic       FS02A = 1'b0;
    logic       F02A  = 1'b0;
    logic       F02B  = 1'b0;
    logic       ALMCLR = 1'b0;
    logic       SCAFAL;
    logic [3:0] FAULT;
    logic [7:0] ERRCNT;
    logic       LOCKED;

    scaler_alarm_monitor #(
        .SETTLE(4), .STALL_MAX(3), .WINDOW(8), .ERRW(8)
    ) dut (
        .FS01_(FS01_), .rst(rst), .FS02(FS02), .FS02A(FS02A), .F02A(F02A),
        .F02B(F02B), .ALMCLR(ALMCLR), .SCAFAL(SCAFAL), .FAULT(FAULT),
        .ERRCNT(ERRCNT), .LOCKED(LOCKED)
    );

    always #5 FS01_ = ~FS01_;

    typedef struct {
        int         due;
        logic       scafal;
        logic [3:0] fault;
        logic [7:0] errcnt;
        logic       locked;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;     // edges since reset release

    function automatic void push_exp(input int due, input logic sc, input logic [3:0] f,
                                     input int e, input logic l);
        exp_t x;
        x.due    = due;
        x.scafal = sc;
        x.fault  = f;
        x.errcnt = e[7:0];
        x.locked = l;
        sb.push_back(x);
    endfunction

    // Drive one sample now, let the next rising edge take it, then settle 1 ns past the edge.
    task automatic tick(input logic fs, input logic fsa, input logic a, input logic b, input logic clr);
        FS02 = fs; FS02A = fsa; F02A = a; F02B = b; ALMCLR = clr;
        @(posedge FS01_);
        #1;
        n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        FS02 = 0; FS02A = 0; F02A = 0; F02B = 0; ALMCLR = 0;
        repeat (3) @(posedge FS01_);
        #1;
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge FS01_);
        #1;
        checks++; if (SCAFAL !== 1'b0) begin errors++; $display("FAIL reset_scafal: got %b want 0", SCAFAL); end
        checks++; if (FAULT !== 4'b0000) begin errors++; $display("FAIL reset_fault: got %b want 0000", FAULT); end
        checks++; if (ERRCNT !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", ERRCNT); end
        checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
    endtask

    // Healthy scaler: FS02 high on even samples, F02A on rises, F02B on falls.
    task automatic test_healthy();
        exp_t e; logic h;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            h = (k % 2 == 0);
            if (k < 100) push_exp(k + 1, 1'b0, 4'b0000, 0, (k + 1) >= 4);
            tick(h, !h, h, !h, 1'b0);
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL healthy edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
    endtask

    // FS02 frozen high from sample 20; third repeat (sample 23) faults, then every sample until saturation.
    task automatic test_stall();
        exp_t e; logic h, a, b; int due;
        do_reset();
        for (int k = 1; k <= 321; k++) begin
            if (k <= 20) begin
                h = (k % 2 == 0); a = h; b = !h;
            end else begin
                h = 1'b1; a = (k % 2 == 0); b = (k % 2 != 0);
            end
            due = k + 1;
            if (k < 321) begin
                if (due <= 23) push_exp(due, 1'b0, 4'b0000, 0, due >= 4);
                else           push_exp(due, 1'b1, 4'b0001, (due - 23 > 255) ? 255 : due - 23, 1'b1);
            end
            tick(h, !h, a, b, 1'b0);
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL stall edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
    endtask

    // One bad complement at sample 30, clean ALMCLR sampled at edge 40.
    task automatic test_complement();
        exp_t e; logic h; int due;
        do_reset();
        for (int k = 1; k <= 51; k++) begin
            h = (k % 2 == 0);
            due = k + 1;
            if (k < 51) begin
                if (due <= 30)      push_exp(due, 1'b0, 4'b0000, 0, due >= 4);
                else if (due <= 40) push_exp(due, 1'b1, 4'b0010, 1, 1'b1);
                else                push_exp(due, 1'b0, 4'b0000, 1, 1'b1);
            end
            tick(h, (k == 30) ? h : !h, h, !h, k == 40);
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL complement edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
    endtask

    // In ALARM, ALMCLR and an A/B overlap share sample 35; a clean ALMCLR at sample 42 then clears.
    task automatic test_clear_with_fault();
        exp_t e; logic h; int due;
        do_reset();
        for (int k = 1; k <= 46; k++) begin
            h = (k % 2 == 0);
            due = k + 1;
            if (k < 46) begin
                if (due <= 30)      push_exp(due, 1'b0, 4'b0000, 0, due >= 4);
                else if (due <= 35) push_exp(due, 1'b1, 4'b0010, 1, 1'b1);
                else if (due <= 42) push_exp(due, 1'b1, 4'b0100, 2, 1'b1);
                else                push_exp(due, 1'b0, 4'b0000, 2, 1'b1);
            end
            tick(h, (k == 30) ? h : !h, h | (k == 35), !h, (k == 35) || (k == 42));
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL clear_with_fault edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
    endtask

    // F02B absent from the first checked sample (4); windows end at samples 11, 19, 27, 35.
    task automatic test_missing_pulse();
        exp_t e; logic h; int due;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            h = (k % 2 == 0);
            due = k + 1;
            if (k < 36) begin
                if (due < 12) push_exp(due, 1'b0, 4'b0000, 0, due >= 4);
                else          push_exp(due, 1'b1, 4'b1000, 1 + (due - 12) / 8, 1'b1);
            end
            tick(h, !h, h, (k >= 4) ? 1'b0 : !h, 1'b0);
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL missing_pulse edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
    endtask

    // Alarm raised, then a 1 us rst pulse between edges; outputs drop at once and lock is re-acquired.
    task automatic test_async_reset();
        exp_t e; logic h; int due;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            h = (k % 2 == 0);
            due = k + 1;
            if (k < 14) begin
                if (due <= 10) push_exp(due, 1'b0, 4'b0000, 0, due >= 4);
                else           push_exp(due, 1'b1, 4'b0010, 1, 1'b1);
            end
            tick(h, (k == 10) ? h : !h, h, !h, 1'b0);
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL async_pre edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (SCAFAL !== 1'b0) begin errors++; $display("FAIL async_scafal: got %b want 0", SCAFAL); end
        checks++; if (FAULT !== 4'b0000) begin errors++; $display("FAIL async_fault: got %b want 0000", FAULT); end
        checks++; if (ERRCNT !== 8'd0) begin errors++; $display("FAIL async_errcnt: got %0d want 0", ERRCNT); end
        checks++; if (LOCKED !== 1'b0) begin errors++; $display("FAIL async_locked: got %b want 0", LOCKED); end
        #999;
        rst = 1'b0;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            h = (k % 2 == 0);
            if (k < 8) push_exp(k + 1, 1'b0, 4'b0000, 0, (k + 1) >= 4);
            tick(h, !h, h, !h, 1'b0);
            while (sb.size() != 0 && sb[0].due <= n) begin
                e = sb.pop_front(); checks++;
                if ({SCAFAL, FAULT, ERRCNT, LOCKED} !== {e.scafal, e.fault, e.errcnt, e.locked}) begin
                    errors++;
                    $display("FAIL async_relock edge %0d: got sc=%b f=%b err=%0d lk=%b want sc=%b f=%b err=%0d lk=%b",
                             n, SCAFAL, FAULT, ERRCNT, LOCKED, e.scafal, e.fault, e.errcnt, e.locked);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_healthy();
        test_stall();
        test_complement();
        test_clear_with_fault();
        test_missing_pulse();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
